alu_fu_pipe: RTL and testbench
==============================

// Module: alu_fu_pipe
// PURPOSE
//  Pipelined integer ALU functional unit between the ALU reservation station and the CDB arbiter.
//  Accepts one issued op per cycle (valid/ready), selects operands, computes the result and carries
//  it with its ROB tag through STAGES registers. Presents the result to the CDB with backpressure.
//  A flush input kills all in-flight ops (mispredict recovery).
// PARAMETERS
//  XLEN    32  operand/result width; 32 or 64
//  TAG_W   5   ROB tag width
//  STAGES  2   pipeline depth; 1..4; accept-to-out_valid latency in cycles
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      asynchronous reset, active-low
//  flush       in   1      kill all in-flight ops
//  in_valid    in   1      RS presents an op
//  in_ready    out  1      unit can accept this cycle
//  in_op       in   4      alu_op_t
//  in_m1_sel   in   2      alu_m1_sel_t: rs1_out / pc_out / no_out
//  in_m2_sel   in   2      alu_m2_sel_t: rs2_out / imm_out / four_out
//  in_rs1      in   XLEN   forwarded rs1 value
//  in_rs2      in   XLEN   forwarded rs2 value
//  in_pc       in   XLEN   instruction PC
//  in_imm      in   XLEN   sign-extended immediate
//  in_tag      in   TAG_W  ROB tag
//  out_valid   out  1      result available for CDB
//  out_ready   in   1      CDB grant
//  out_tag     out  TAG_W  ROB tag of result
//  out_result  out  XLEN   result
//  busy        out  1      any stage valid
// BEHAVIOUR
//  - Reset (rst low, async): all stage valid bits 0; out_valid=0, busy=0, out_tag=0, out_result=0.
//    in_ready=1 from the first edge after release.
//  - Transfer in on in_valid&&in_ready; transfer out on out_valid&&out_ready.
//  - Operand a: rs1_out->in_rs1, pc_out->in_pc, no_out/other->0.
//    Operand b: rs2_out->in_rs2, imm_out->in_imm, four_out->4, other->0.
//  - Result computed combinationally at accept and registered into stage 0; later stages carry {tag,result}.
//  - Ops: add a+b; sub a-b; xor/or/and bitwise; sll a<<sh; srl a>>sh; sra arithmetic >>.
//    slt signed a<b ->1 else 0; sltu unsigned a<b ->1 else 0; unknown op -> 0.
//    sh = b[$clog2(XLEN)-1:0]; all arithmetic modulo 2^XLEN, no flags.
//  - Stage i advances when stage i+1 empty or itself advancing; last stage advances on out_ready.
//    Bubbles collapse: an op behind an empty stage moves forward even while the output is stalled.
//  - in_ready = !stage0_valid || stage0 advancing (combinational from out_ready through the chain).
//  - Latency: STAGES cycles from accept to out_valid with no stall.
//    Throughput 1/cycle with out_ready held high.
//  - Stall: out_tag/out_result are stable while out_valid && !out_ready.
//  - flush: every valid bit cleared at the next edge. While flush=1, out_valid and in_ready are
//    forced 0, so no transfer completes in a flush cycle. One cycle of flush is enough.
//  - Reset mid-operation discards all ops; no partial result reaches the outputs.
//  - busy = OR of stage valid bits.
// CONFIGURATION
//  - ALU_ZBA_EN defined: adds sh1add/sh2add/sh3add, result (a<<1|2|3)+b.
//  - ALU_ZBA_EN undefined: those encodings are unknown ops -> result 0.
// STRUCTURE
//  - Shared package rv32_alu_pkg:
//    - alu_op_t: add=0, sll=1, slt=2, sltu=3, xor=4, srl=5, or=6, and=7, sub=8, sra=9,
//      sh1add=10, sh2add=11, sh3add=12.
//    - alu_m1_sel_t: rs1_out=0, pc_out=1, no_out=2.
//    - alu_m2_sel_t: rs2_out=0, imm_out=1, four_out=2.
//    - alu_fu_stage_t: struct {valid, tag, result}.
//  - Sub-module alu_core: purely combinational (op, a, b) -> result.
//    This module holds operand muxing, the stage array and the handshake.
// TESTING
//  1. XLEN=32, STAGES=2: add, m1=rs1, m2=imm, rs1=5, imm=-3, tag=7, out_ready=1
//     -> out_valid 2 cycles after accept; result=2, tag=7.
//  2. Back-to-back sra rs1=0x80000000, rs2=4 then sltu rs1=1, rs2=0xFFFFFFFF, out_ready=1
//     -> consecutive cycles: 0xF8000000, then 1.
//  3. out_ready=0 for 5 cycles, in_valid=1 throughout -> exactly STAGES ops accepted, in_ready=0,
//     outputs stable; then out_ready=1 drains them in order, 1/cycle.
//  4. flush with 2 in flight and in_valid=1 -> no out_valid for those tags; in_ready=0 in the flush
//     cycle; busy=0 on the next cycle.
//  5. rst low while out_valid=1 -> out_valid=0 immediately (async), no result after release.
//  6. ALU_ZBA_EN defined: sh2add a=3, b=10 -> 22; undefined: same op -> 0.

Source files
------------

// File: rtl/rv32_alu_pkg.sv
// Shared ALU types: op encoding, operand selects, stage bundle.
// ALU_ZBA_EN enables the sh1add/sh2add/sh3add encodings.
package rv32_alu_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int TAG_W_DEF = 5;

  typedef enum logic [3:0] {
    alu_add    = 4'd0,
    alu_sll    = 4'd1,
    alu_slt    = 4'd2,
    alu_sltu   = 4'd3,
    alu_xor    = 4'd4,
    alu_srl    = 4'd5,
    alu_or     = 4'd6,
    alu_and    = 4'd7,
    alu_sub    = 4'd8,
    alu_sra    = 4'd9,
    alu_sh1add = 4'd10,
    alu_sh2add = 4'd11,
    alu_sh3add = 4'd12
  } alu_op_t;

  typedef enum logic [1:0] {
    rs1_out = 2'd0,
    pc_out  = 2'd1,
    no_out  = 2'd2
  } alu_m1_sel_t;

  typedef enum logic [1:0] {
    rs2_out  = 2'd0,
    imm_out  = 2'd1,
    four_out = 2'd2
  } alu_m2_sel_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_DEF-1:0] tag;
    logic [XLEN_DEF-1:0]  result;
  } alu_fu_stage_t;

endpackage

// File: rtl/alu_core.sv
// Combinational integer ALU datapath (op, a, b) -> result.
// ALU_ZBA_EN adds shifted-add ops; otherwise they decode to zero.
module alu_core
  import rv32_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_t         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] sh;
  logic           lt_s;
  logic           lt_u;

  assign sh   = b[SHW-1:0];
  assign lt_s = $signed(a) < $signed(b);
  assign lt_u = a < b;

  always_comb begin
    result = '0;
    unique case (op)
      alu_add:    result = a + b;
      alu_sub:    result = a - b;
      alu_xor:    result = a ^ b;
      alu_or:     result = a | b;
      alu_and:    result = a & b;
      alu_sll:    result = a << sh;
      alu_srl:    result = a >> sh;
      alu_sra:    result = $signed(a) >>> sh;
      alu_slt:    result = {{(XLEN-1){1'b0}}, lt_s};
      alu_sltu:   result = {{(XLEN-1){1'b0}}, lt_u};
`ifdef ALU_ZBA_EN
      alu_sh1add: result = (a << 1) + b;
      alu_sh2add: result = (a << 2) + b;
      alu_sh3add: result = (a << 3) + b;
`endif
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/alu_fu_pipe.sv
// Pipelined ALU functional unit: operand select, STAGES-deep result pipe, CDB handshake.
// ALU_ZBA_EN (see alu_core) enables shifted-add ops.
module alu_fu_pipe
  import rv32_alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int TAG_W  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_op_t          in_op,
  input  alu_m1_sel_t      in_m1_sel,
  input  alu_m2_sel_t      in_m2_sel,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [XLEN-1:0]  out_result,
  output logic             busy
);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  result;
  } stage_t;

  localparam int LAST = STAGES - 1;

  stage_t          st [STAGES];
  logic [LAST:0]   v;
  logic [LAST:0]   adv;
  logic            full;
  logic            out_go;
  logic            acc;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic [XLEN-1:0] res;

  always_comb begin
    opa = '0;
    unique case (in_m1_sel)
      rs1_out: opa = in_rs1;
      pc_out:  opa = in_pc;
      default: opa = '0;
    endcase
  end

  always_comb begin
    opb = '0;
    unique case (in_m2_sel)
      rs2_out:  opb = in_rs2;
      imm_out:  opb = in_imm;
      four_out: opb = XLEN'(4);
      default:  opb = '0;
    endcase
  end

  alu_core #(
    .XLEN(XLEN)
  ) u_core (
    .op    (in_op),
    .a     (opa),
    .b     (opb),
    .result(res)
  );

  always_comb begin
    v = '0;
    for (int i = 0; i < STAGES; i++)
      v[i] = st[i].valid;
  end

  assign out_go = v[LAST] & out_ready & ~flush;

  // A stage moves if any later stage is empty or the output drains.
  always_comb begin
    adv  = '0;
    full = 1'b1;
    for (int i = 0; i < STAGES; i++) begin
      full = 1'b1;
      for (int j = i + 1; j < STAGES; j++)
        full = full & v[j];
      adv[i] = v[i] & (out_go | ~full);
    end
  end

  assign in_ready   = (~v[0] | adv[0]) & ~flush;
  assign acc        = in_valid & in_ready;
  assign out_valid  = v[LAST] & ~flush;
  assign out_tag    = st[LAST].tag;
  assign out_result = st[LAST].result;
  assign busy       = |v;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < STAGES; i++)
        st[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < STAGES; i++)
        st[i].valid <= 1'b0;
    end else begin
      if (acc)
        st[0] <= '{valid: 1'b1, tag: in_tag, result: res};
      else if (adv[0])
        st[0].valid <= 1'b0;
      for (int i = 1; i < STAGES; i++) begin
        if (adv[i-1])
          st[i] <= st[i-1];
        else if (adv[i])
          st[i].valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_fu_pipe.sv
// Self-checking bench for alu_fu_pipe: in-order scoreboard with age-based timing model.
// Build with ALU_ZBA_EN to exercise shifted-add ops.
module tb_alu_fu_pipe;
  import rv32_alu_pkg::*;

  localparam int XLEN   = 32;
  localparam int TAG_W  = 5;
  localparam int STAGES = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  alu_op_t          in_op = alu_add;
  alu_m1_sel_t      in_m1_sel = rs1_out;
  alu_m2_sel_t      in_m2_sel = rs2_out;
  logic [XLEN-1:0]  in_rs1 = '0;
  logic [XLEN-1:0]  in_rs2 = '0;
  logic [XLEN-1:0]  in_pc = '0;
  logic [XLEN-1:0]  in_imm = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [TAG_W-1:0] out_tag;
  logic [XLEN-1:0]  out_result;
  logic             busy;

  alu_fu_pipe #(
    .XLEN(XLEN), .TAG_W(TAG_W), .STAGES(STAGES)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_m1_sel(in_m1_sel), .in_m2_sel(in_m2_sel),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm),
    .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_tag(out_tag), .out_result(out_result), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_acc = 0;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  res;
    int               t;
  } exp_t;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  res;
    int               lat;
    int               oc;
  } obs_t;

  exp_t q[$];
  obs_t seen[$];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(int op, logic [31:0] a, logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      0: return a + b;
      1: return a << sh;
      2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3: return (a < b) ? 32'd1 : 32'd0;
      4: return a ^ b;
      5: return a >> sh;
      6: return a | b;
      7: return a & b;
      8: return a - b;
      9: return 32'($signed(a) >>> sh);
`ifdef ALU_ZBA_EN
      10, 11, 12: return (a << (op - 9)) + b;
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] opnd_a();
    case (int'(in_m1_sel))
      0: return in_rs1;
      1: return in_pc;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] opnd_b();
    case (int'(in_m2_sel))
      0: return in_rs2;
      1: return in_imm;
      2: return 32'd4;
      default: return 32'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    logic eov;
    logic eir;
    if (!rst) begin
      q.delete();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);
      chk("rst_out_result", 64'(out_result), 64'd0);
    end else begin
      eov = !flush && q.size() > 0 && (cyc - q[0].t) >= STAGES;
      eir = !flush && (q.size() < STAGES || out_ready);
      chk("out_valid", 64'(out_valid), 64'(eov));
      chk("in_ready", 64'(in_ready), 64'(eir));
      chk("busy", 64'(busy), 64'(q.size() > 0));
      if (eov) begin
        chk("out_tag", 64'(out_tag), 64'(q[0].tag));
        chk("out_result", 64'(out_result), 64'(q[0].res));
        if (out_ready) begin
          seen.push_back('{q[0].tag, q[0].res, cyc - q[0].t, cyc});
          void'(q.pop_front());
        end
      end
      if (flush) begin
        q.delete();
      end else if (in_valid && eir) begin
        q.push_back('{in_tag, ref_alu(int'(in_op), opnd_a(), opnd_b()), cyc});
        n_acc++;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(int op, int m1, int m2, logic [31:0] rs1,
                        logic [31:0] rs2, logic [31:0] imm, int tag);
    in_op     = alu_op_t'(4'(op));
    in_m1_sel = alu_m1_sel_t'(2'(m1));
    in_m2_sel = alu_m2_sel_t'(2'(m2));
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
    in_pc     = 32'h0000_1000;
    in_tag    = TAG_W'(tag);
  endtask

  task automatic wait_seen(string nm, int n, int lim);
    int k;
    k = 0;
    while (seen.size() < n && k < lim) begin
      step();
      k++;
    end
    chk(nm, 64'(seen.size() >= n), 64'd1);
  endtask

  initial begin
    int base;
    int b0;
    // pin the reference model with hand-computed values
    chk("ref_add", 64'(ref_alu(0, 32'd5, 32'hFFFF_FFFD)), 64'd2);
    chk("ref_sra", 64'(ref_alu(9, 32'h8000_0000, 32'd4)), 64'hF800_0000);
    chk("ref_sltu", 64'(ref_alu(3, 32'd1, 32'hFFFF_FFFF)), 64'd1);
    chk("ref_slt", 64'(ref_alu(2, 32'hFFFF_FFFF, 32'd1)), 64'd1);

    repeat (3) step();
    rst = 1'b1;
    step();

    // 1: add rs1 + imm, latency STAGES
    out_ready = 1'b1;
    base = seen.size();
    set_op(0, 0, 1, 32'd5, 32'd0, 32'hFFFF_FFFD, 7);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_seen("t1_wait", base + 1, 10);
    if (seen.size() > base) begin
      chk("t1_result", 64'(seen[base].res), 64'd2);
      chk("t1_tag", 64'(seen[base].tag), 64'd7);
      chk("t1_latency", 64'(seen[base].lat), 64'(STAGES));
    end

    // 2: back-to-back sra then sltu
    base = seen.size();
    set_op(9, 0, 0, 32'h8000_0000, 32'd4, 32'd0, 1);
    in_valid = 1'b1;
    step();
    set_op(3, 0, 0, 32'd1, 32'hFFFF_FFFF, 32'd0, 2);
    step();
    in_valid = 1'b0;
    wait_seen("t2_wait", base + 2, 10);
    if (seen.size() > base + 1) begin
      chk("t2_sra", 64'(seen[base].res), 64'hF800_0000);
      chk("t2_sltu", 64'(seen[base+1].res), 64'd1);
      chk("t2_consec", 64'(seen[base+1].oc - seen[base].oc), 64'd1);
    end

    // 3: stall with in_valid held, then drain
    out_ready = 1'b0;
    base = n_acc;
    for (int k = 0; k < 5; k++) begin
      set_op(k % 10, 0, 0, 32'($urandom), 32'($urandom), 32'd0, 10 + k);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    #1;
    chk("t3_accepted", 64'(n_acc - base), 64'(STAGES));
    chk("t3_in_ready", 64'(in_ready), 64'd0);
    chk("t3_out_valid", 64'(out_valid), 64'd1);
    b0 = seen.size();
    out_ready = 1'b1;
    wait_seen("t3_wait", b0 + 2, 10);
    if (seen.size() > b0 + 1) begin
      chk("t3_first_tag", 64'(seen[b0].tag), 64'd10);
      chk("t3_second_tag", 64'(seen[b0+1].tag), 64'd11);
      chk("t3_consec", 64'(seen[b0+1].oc - seen[b0].oc), 64'd1);
    end

    // 4: flush with two in flight
    out_ready = 1'b0;
    set_op(0, 0, 2, 32'd20, 32'd0, 32'd0, 20);
    in_valid = 1'b1;
    step();
    set_op(0, 0, 2, 32'd21, 32'd0, 32'd0, 21);
    step();
    set_op(0, 0, 2, 32'd22, 32'd0, 32'd0, 22);
    flush = 1'b1;
    #1;
    chk("t4_in_ready", 64'(in_ready), 64'd0);
    chk("t4_out_valid", 64'(out_valid), 64'd0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("t4_busy", 64'(busy), 64'd0);
    out_ready = 1'b1;
    base = seen.size();
    repeat (5) step();
    chk("t4_no_result", 64'(seen.size() - base), 64'd0);

    // 5: async reset while a result is waiting
    out_ready = 1'b0;
    set_op(8, 0, 1, 32'd9, 32'd0, 32'd3, 25);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("t5_pre_valid", 64'(out_valid), 64'd1);
    rst = 1'b0;
    #1;
    chk("t5_async_valid", 64'(out_valid), 64'd0);
    chk("t5_async_busy", 64'(busy), 64'd0);
    repeat (2) step();
    rst = 1'b1;
    out_ready = 1'b1;
    base = seen.size();
    repeat (5) step();
    chk("t5_no_result", 64'(seen.size() - base), 64'd0);

    // 6: sh2add
    base = seen.size();
    set_op(11, 0, 0, 32'd3, 32'd10, 32'd0, 3);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_seen("t6_wait", base + 1, 10);
    if (seen.size() > base) begin
`ifdef ALU_ZBA_EN
      chk("t6_sh2add", 64'(seen[base].res), 64'd22);
`else
      chk("t6_sh2add", 64'(seen[base].res), 64'd0);
`endif
    end

    // random traffic against the scoreboard
    for (int k = 0; k < 400; k++) begin
      set_op($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3),
             ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : 32'($urandom),
             ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom),
             32'($urandom), $urandom_range(0, 31));
      in_pc     = 32'($urandom);
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      flush     = $urandom_range(0, 29) == 0;
      step();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (8) step();
    chk("drain_busy", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
